pkt_framer: RTL and testbench
=============================

Name: pkt_framer

Overview:
- Transmit-side packetizer that builds a framed packet stream from unframed data words.
- Takes one length descriptor per packet, then pulls exactly the number of data beats that length needs.
- Emits a valid/ready stream with sop, eop and symbol-count empty, suitable for feeding the packet FIFO wrapper's input side.
- Sits between DMA/payload producers and the packet FIFO in the RX/TX datapath.

Parameters:
- SYMBOL_PER_BEATS, 8, symbols per data beat; must be a power of 2, 1 or more.
- BITS_PER_SYMBOL, 8, bits per symbol.
- LEN_WIDTH, 16, width of the descriptor length field, in symbols.
- Derived: DW = BITS_PER_SYMBOL*SYMBOL_PER_BEATS; EW = max(1, clog2(SYMBOL_PER_BEATS)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- desc_valid  in  1  descriptor valid.
- desc_ready  out  1  descriptor accepted when desc_valid && desc_ready.
- desc_len  in  LEN_WIDTH  packet length in symbols.
- in_valid  in  1  unframed data beat valid.
- in_ready  out  1  framer accepts the data beat.
- in_data  in  DW  data beat.
- out_valid  out  1  framed beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DW  registered data.
- out_sop  out  1  first beat of the packet.
- out_eop  out  1  last beat of the packet.
- out_empty  out  EW  unused symbols in the eop beat; 0 on all other beats.
- stat_pkt_cnt  out  32  packets emitted (optional feature).
- stat_zero_cnt  out  32  zero-length descriptors dropped (optional feature).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Reset values: state=IDLE, out_valid=0, out_data=0, out_sop=0, out_eop=0, out_empty=0, internal counters=0, stats=0.
- desc_ready = (state==IDLE) && !rst. in_ready = (state==SEND) && (!out_valid || out_ready) && !rst.

State IDLE:
- On a descriptor fire with desc_len==0: the descriptor is dropped, stat_zero_cnt increments, and the block stays in IDLE.
- On a descriptor fire with desc_len>0:
  - beats_left <= ceil(desc_len/SYMBOL_PER_BEATS).
  - last_empty <= (SYMBOL_PER_BEATS - desc_len mod SYMBOL_PER_BEATS) mod SYMBOL_PER_BEATS.
  - first <= 1.
  - Go to SEND.
- beats_left is LEN_WIDTH bits wide. The ceil is computed without overflow at desc_len = 2^LEN_WIDTH-1.

State SEND, on each in fire:
- out_data<=in_data.
- out_sop<=first; first<=0.
- out_eop<=(beats_left==1).
- out_empty<=(beats_left==1)?last_empty:0.
- out_valid<=1; beats_left decrements.
- On the eop beat, go to IDLE.

Output register:
- Latency from in fire to out_valid is 1 cycle.
- While out_valid && !out_ready, out_data, out_sop, out_eop and out_empty hold stable and in_ready=0.
- If out_ready=1, a new beat may load in the same cycle the previous beat fires, so throughput is 1 beat/cycle.
- out_valid clears on an out fire with no simultaneous in fire.

Packet boundaries:
- There is a mandatory 1-cycle bubble between packets: descriptors are accepted only in IDLE.
- The eop beat may still be held in the output register while the next descriptor is accepted.
- Single-beat packet: sop=eop=1 on the same beat.

Reset mid-packet: the partial packet is abandoned, out_valid=0 in the cycle after rst, and no eop is emitted.

desc_len, in_data and in_valid are ignored outside their own handshake states.

Optional Feature:
- Macro: PKT_FRAMER_STATS_EN.
- Defined:
  - stat_pkt_cnt increments by 1 on each out fire with out_eop=1.
  - stat_zero_cnt increments on each dropped zero-length descriptor.
  - Both counters are 32 bits, wrap 0xFFFFFFFF->0, and are cleared by rst.
- Undefined: both ports are tied to 0, no counter flops exist, and the framing behaviour is identical.

Test Plan:
- SYMBOL_PER_BEATS=8, desc_len=20, in_valid and out_ready held 1 -> 3 beats on consecutive cycles starting 1 cycle after the first in fire; sop on beat0, eop on beat2, out_empty=4 on beat2 and 0 on the others.
- desc_len=16, then desc_len=1 back to back -> packet A is 2 beats with out_empty=0; packet B is 1 beat with sop=eop=1 and out_empty=7; exactly one idle cycle of desc_ready between them.
- desc_len=0 -> no output beat, in_ready stays 0, desc_ready is 1 the next cycle; with the macro, stat_zero_cnt=1.
- desc_len=24, out_ready=0 for 5 cycles after beat0 -> out_data/out_sop held stable, in_ready=0 for those cycles, no beat lost or duplicated, 3 beats total.
- rst pulsed for 1 cycle after beat1 of a 4-beat packet -> out_valid=0, desc_ready=1 the next cycle, no eop seen; a following desc_len=8 emits one clean sop/eop beat.
- PKT_FRAMER_STATS_EN defined, 10 packets of random length 1..100 -> stat_pkt_cnt=10 and the beat count matches ceil(len/8) for each packet.

Source files
------------

// File: rtl/pkt_framer.sv
// Transmit packetizer: one length descriptor in, ceil(len/SYMBOL_PER_BEATS) framed beats out.
// Optional PKT_FRAMER_STATS_EN adds packet and dropped-zero-length counters.
module pkt_framer #(
  parameter int SYMBOL_PER_BEATS = 8,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int LEN_WIDTH        = 16,
  localparam int DW = BITS_PER_SYMBOL * SYMBOL_PER_BEATS,
  localparam int EW = (SYMBOL_PER_BEATS > 1) ? $clog2(SYMBOL_PER_BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [LEN_WIDTH-1:0] desc_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [EW-1:0]        out_empty,
  output logic [31:0]          stat_pkt_cnt,
  output logic [31:0]          stat_zero_cnt
);

  localparam int LOG2_SPB = $clog2(SYMBOL_PER_BEATS);
  localparam logic [LEN_WIDTH-1:0] SYM_COUNT = LEN_WIDTH'(SYMBOL_PER_BEATS);
  localparam logic [LEN_WIDTH-1:0] SYM_MASK  = LEN_WIDTH'(SYMBOL_PER_BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // Shift-plus-carry ceil so the all-ones length cannot overflow.
  function automatic logic [LEN_WIDTH-1:0] f_ceil_beats(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH-1:0] rem;
    rem = len & SYM_MASK;
    return (len >> LOG2_SPB) + LEN_WIDTH'(rem != '0);
  endfunction

  function automatic logic [EW-1:0] f_last_empty(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH-1:0] pad;
    pad = (SYM_COUNT - (len & SYM_MASK)) & SYM_MASK;
    return EW'(pad);
  endfunction

  logic [0:0]           r_state;
  logic [LEN_WIDTH-1:0] r_beats_left;
  logic [EW-1:0]        r_last_empty;
  logic                 r_first;
  logic                 r_vld_p1;
  logic [DW-1:0]        r_data_p1;
  logic                 r_sop_p1;
  logic                 r_eop_p1;
  logic [EW-1:0]        r_empty_p1;

  logic w_desc_fire;
  logic w_in_fire;
  logic w_out_fire;
  logic w_last_beat;

  assign desc_ready  = (r_state == S_IDLE) && !rst;
  assign in_ready    = (r_state == S_SEND) && (!r_vld_p1 || out_ready) && !rst;
  assign w_desc_fire = desc_valid && desc_ready;
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_vld_p1 && out_ready;
  assign w_last_beat = (r_beats_left == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_beats_left <= '0;
      r_last_empty <= '0;
      r_first      <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_data_p1    <= '0;
      r_sop_p1     <= 1'b0;
      r_eop_p1     <= 1'b0;
      r_empty_p1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_desc_fire && (desc_len != '0)) begin
            r_beats_left <= f_ceil_beats(desc_len);
            r_last_empty <= f_last_empty(desc_len);
            r_first      <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_in_fire) begin
            r_first      <= 1'b0;
            r_beats_left <= r_beats_left - LEN_WIDTH'(1);
            if (w_last_beat) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Output stage (p1): reloads in the same cycle the held beat drains.
      if (w_in_fire) begin
        r_vld_p1   <= 1'b1;
        r_data_p1  <= in_data;
        r_sop_p1   <= r_first;
        r_eop_p1   <= w_last_beat;
        r_empty_p1 <= w_last_beat ? r_last_empty : '0;
      end else if (w_out_fire) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_sop   = r_sop_p1;
  assign out_eop   = r_eop_p1;
  assign out_empty = r_empty_p1;

`ifdef PKT_FRAMER_STATS_EN
  logic [31:0] r_stat_pkt_cnt;
  logic [31:0] r_stat_zero_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_pkt_cnt  <= '0;
      r_stat_zero_cnt <= '0;
    end else begin
      if (w_out_fire && r_eop_p1) r_stat_pkt_cnt <= r_stat_pkt_cnt + 32'd1;
      if (w_desc_fire && (desc_len == '0)) r_stat_zero_cnt <= r_stat_zero_cnt + 32'd1;
    end
  end

  assign stat_pkt_cnt  = r_stat_pkt_cnt;
  assign stat_zero_cnt = r_stat_zero_cnt;
`else
  assign stat_pkt_cnt  = 32'd0;
  assign stat_zero_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_framer.sv
// Scoreboard bench for pkt_framer: packets expanded from descriptor lengths into expected
// beats at descriptor time, popped and compared by a negedge monitor on every output fire.
module tb_pkt_framer;
  localparam int SPB   = 8;
  localparam int DW    = 64;
  localparam int EW    = 3;
  localparam int NWORD = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_valid;
  logic          desc_ready;
  logic [15:0]   desc_len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [EW-1:0] out_empty;
  logic [31:0]   stat_pkt_cnt;
  logic [31:0]   stat_zero_cnt;

  pkt_framer #(.SYMBOL_PER_BEATS(SPB), .BITS_PER_SYMBOL(8), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_zero_cnt(stat_zero_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] words[NWORD];
  int            rd_idx;
  int            n_pass = 0;
  int            n_total = 0;
  int            in_prob = 100;
  int            out_prob = 100;
  int            ord_mode = 0;
  bit            gap_chk = 0;

  int    pull_left = 0;
  int    m_pkt = 0;
  int    m_zero = 0;
  int    beats_fired = 0;
  int    cyc = 0;
  int    last_fire_cyc = 0;
  bit    prev_in_fire = 0;
  bit    prev_out_fire = 0;
  bit    prev_stall = 0;
  beat_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_stats();
`ifdef PKT_FRAMER_STATS_EN
    chk("stat_pkt_cnt", stat_pkt_cnt, 64'(m_pkt));
    chk("stat_zero_cnt", stat_zero_cnt, 64'(m_zero));
`else
    chk("stat_pkt_cnt_tied", stat_pkt_cnt, 0);
    chk("stat_zero_cnt_tied", stat_zero_cnt, 0);
`endif
  endtask

  // Data source: a fixed random word sequence, advanced on every accepted beat.
  initial begin
    bit f;
    for (int i = 0; i < NWORD; i++) words[i] = {$urandom, $urandom};
    rd_idx   = 0;
    in_data  = words[0];
    in_valid = 1'b0;
    forever begin
      @(negedge clk);
      f = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (f) rd_idx++;
      in_data  = words[rd_idx % NWORD];
      in_valid = ($urandom_range(99) < in_prob);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ord_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(99) < out_prob);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / reference model.
  always @(negedge clk) begin
    bit    d_fire, i_fire, o_fire;
    int    len, nb;
    beat_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      pull_left     = 0;
      m_pkt         = 0;
      m_zero        = 0;
      prev_in_fire  = 0;
      prev_out_fire = 0;
      prev_stall    = 0;
    end else begin
      d_fire = desc_valid && desc_ready;
      i_fire = in_valid && in_ready;
      o_fire = out_valid && out_ready;
      chk("desc_ready", desc_ready, 64'(pull_left == 0));
      chk("in_ready", in_ready, 64'((pull_left > 0) && (!out_valid || out_ready)));
      if (prev_in_fire) chk("latency_vld", out_valid, 1);
      else if (prev_out_fire) chk("vld_clear", out_valid, 0);
      if (prev_stall) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_data", out_data, held.data);
        chk("hold_flags", {out_sop, out_eop, out_empty}, {held.sop, held.eop, held.empty});
      end
      if (d_fire) begin
        len = int'(desc_len);
        if (len == 0) m_zero++;
        else begin
          nb = (len + SPB - 1) / SPB;
          for (int b = 0; b < nb; b++) begin
            e.data  = words[(rd_idx + b) % NWORD];
            e.sop   = (b == 0);
            e.eop   = (b == nb - 1);
            e.empty = (b == nb - 1 && (len % SPB) != 0) ? EW'(SPB - len % SPB) : '0;
            exp_q.push_back(e);
          end
          pull_left = nb;
        end
      end
      if (i_fire) pull_left--;
      if (o_fire) begin
        beats_fired++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got data %0h sop %0b eop %0b, required no beat", out_data, out_sop, out_eop);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_sop_eop_empty", {out_sop, out_eop, out_empty}, {e.sop, e.eop, e.empty});
          if (e.eop) m_pkt++;
          if (gap_chk && !e.sop) chk("throughput", 64'(cyc), 64'(last_fire_cyc + 1));
        end
        last_fire_cyc = cyc;
      end
      prev_in_fire  = i_fire;
      prev_out_fire = o_fire;
      prev_stall    = out_valid && !out_ready;
      held.data  = out_data;
      held.sop   = out_sop;
      held.eop   = out_eop;
      held.empty = out_empty;
    end
  end

  task automatic send(input int len);
    bit done;
    done = 0;
    @(posedge clk);
    #1;
    desc_valid = 1'b1;
    desc_len   = 16'(len);
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge clk);
      if (desc_ready) done = 1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL desc_timeout: descriptor len %0d not accepted, required acceptance", len);
    end
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    desc_len   = 16'($urandom);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && pull_left == 0 && !out_valid) done = 1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL idle_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    int base, len;
    rst        = 1'b1;
    desc_valid = 1'b0;
    desc_len   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_flags", {out_sop, out_eop, out_empty}, 0);
    chk("rst_in_ready", in_ready, 0);
    chk_stats();

    gap_chk = 1;
    send(20);
    wait_idle();
    gap_chk = 0;

    send(16);
    send(1);
    wait_idle();

    send(0);
    wait_idle();
    chk_stats();

    send(24);
    for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
    ord_mode = 2;
    repeat (5) @(posedge clk);
    ord_mode = 0;
    wait_idle();

    in_prob  = 70;
    out_prob = 70;
    ord_mode = 1;
    for (int p = 0; p < 14; p++) begin
      len = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(100, 1));
      send(len);
    end
    wait_idle();
    chk_stats();

    in_prob  = 100;
    ord_mode = 0;
    send(65535);
    wait_idle();
    chk_stats();

    send(32);
    base = beats_fired;
    for (int t = 0; t < 100 && beats_fired < base + 2; t++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_desc_ready", desc_ready, 1);
    chk_stats();
    send(8);
    wait_idle();
    chk_stats();
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
